led7_scan_mux: RTL and testbench

Time-multiplexed scanner for the multi-digit 7-segment display of the clock. It takes a packed vector of BCD digits from the timekeeping counters and presents one digit at a time on `bcd_out`, which feeds the BCD-to-7-segment decoder. It also drives the active-low digit enables and the decimal point, with an inter-digit blanking gap to suppress ghosting. Digits are snapshotted once per frame so the display never tears mid-frame.

---
 rtl/led7_scan_mux.sv | 133 +++++++++++++
 tb/tb_led7_scan_mux.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/led7_scan_mux.sv
// Time-multiplexed 7-segment digit scanner: per-frame snapshot of the BCD digits,
// one digit per slot with a leading blank gap, optional leading-zero blanking.
module led7_scan_mux #(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   digits_bcd,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [N_DIGITS-1:0]     dig_sel_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   snap_bcd_q, snap_bcd_d;
  logic [N_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [3:0]              bcd_out_q, bcd_out_d;
  logic [N_DIGITS-1:0]     dig_sel_n_q, dig_sel_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    show;
  logic                    upper_zero;
  logic [3:0]              cur_code;
  logic                    cur_dp;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    idx_d        = idx_q;
    snap_bcd_d   = snap_bcd_q;
    snap_dp_d    = snap_dp_q;
    frame_tick_d = 1'b0;

    if (rst || !en) begin
      state_d    = ST_IDLE;
      cyc_d      = '0;
      idx_d      = '0;
      snap_bcd_d = '0;
      snap_dp_d  = '0;
    end else if (state_q == ST_IDLE) begin
      state_d      = ST_RUN;
      cyc_d        = '0;
      idx_d        = '0;
      snap_bcd_d   = digits_bcd;
      snap_dp_d    = dp_in;
      frame_tick_d = 1'b1;
    end else if (cyc_q == SCAN_LAST) begin
      cyc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        snap_bcd_d   = digits_bcd;
        snap_dp_d    = dp_in;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cyc_d = cyc_q + CNT_W'(1);
    end

    // Outputs are derived from the post-edge state so they line up with the slot.
    show        = (state_d == ST_RUN) && (cyc_d >= BLANK_LIM);
    upper_zero  = 1'b1;
    cur_code    = 4'hF;
    cur_dp      = 1'b0;
    dig_sel_n_d = '1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        cur_code = snap_bcd_d[4*i +: 4];
        cur_dp   = snap_dp_d[i];
        if (show) dig_sel_n_d[i] = 1'b0;
      end
      if ((IDX_W'(i) >= idx_d) && (snap_bcd_d[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end

    bcd_out_d = 4'hF;
    dp_n_d    = 1'b1;
    if (show && !(blank_lz && (idx_d != '0) && upper_zero)) begin
      bcd_out_d = cur_code;
      dp_n_d    = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      idx_q        <= '0;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      bcd_out_q    <= 4'hF;
      dig_sel_n_q  <= '1;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      idx_q        <= idx_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      bcd_out_q    <= bcd_out_d;
      dig_sel_n_q  <= dig_sel_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign dig_sel_n  = dig_sel_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led7_scan_mux.sv
// Directed bench for led7_scan_mux with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
module tb_led7_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_sel_n;
  logic        dp_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  led7_scan_mux #(
    .N_DIGITS (4),
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .digits_bcd(digits_bcd),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .bcd_out   (bcd_out),
    .dig_sel_n (dig_sel_n),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, " sel"},  32'(dig_sel_n),  32'hF);
    check_eq({tag, " bcd"},  32'(bcd_out),    32'hF);
    check_eq({tag, " dp"},   32'(dp_n),       32'h1);
    check_eq({tag, " tick"}, 32'(frame_tick), 32'h0);
  endtask

  // codes[4s+:4] is the bcd_out expected in slot s's SHOW phase, dpn[s] its dp_n.
  task automatic run_cycles(input int n, input logic [15:0] codes, input logic [3:0] dpn);
    int          slot;
    int          c;
    logic [3:0]  e_sel;
    logic [3:0]  e_bcd;
    logic        e_dp;
    for (int k = 0; k < n; k++) begin
      step();
      slot  = (t / 8) % 4;
      c     = t % 8;
      e_sel = 4'hF;
      e_bcd = 4'hF;
      e_dp  = 1'b1;
      if (c >= 2) begin
        e_sel = ~(4'b0001 << slot);
        e_bcd = codes[slot*4 +: 4];
        e_dp  = dpn[slot];
      end
      check_eq($sformatf("t%0d sel", t),  32'(dig_sel_n),  32'(e_sel));
      check_eq($sformatf("t%0d bcd", t),  32'(bcd_out),    32'(e_bcd));
      check_eq($sformatf("t%0d dp", t),   32'(dp_n),       32'(e_dp));
      check_eq($sformatf("t%0d tick", t), 32'(frame_tick), 32'(t % 32 == 0));
      check_eq($sformatf("t%0d onehot", t), 32'($countones(~dig_sel_n) <= 1), 32'h1);
      t++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    digits_bcd = 16'h1234;
    dp_in      = 4'b0000;
    blank_lz   = 1'b0;

    for (int k = 0; k < 3; k++) begin
      step();
      check_off($sformatf("reset%0d", k));
    end

    rst = 1'b0;
    t   = 0;
    run_cycles(32 * 5, 16'h1234, 4'hF);

    // Mid-frame change lands three cycles into slot 1 and must wait for the reload.
    run_cycles(11, 16'h1234, 4'hF);
    digits_bcd = 16'h5678;
    run_cycles(21, 16'h1234, 4'hF);
    run_cycles(32, 16'h5678, 4'hF);

    digits_bcd = 16'h0070;
    blank_lz   = 1'b1;
    run_cycles(32, 16'hFF70, 4'hF);
    digits_bcd = 16'h0000;
    run_cycles(32, 16'hFFF0, 4'hF);
    digits_bcd = 16'h0070;
    blank_lz   = 1'b0;
    run_cycles(32, 16'h0070, 4'hF);

    digits_bcd = 16'h1234;
    dp_in      = 4'b0100;
    run_cycles(32, 16'h1234, 4'b1011);

    run_cycles(20, 16'h1234, 4'b1011);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_off($sformatf("en_off%0d", k));
    end
    digits_bcd = 16'h4321;
    en         = 1'b1;
    t          = 0;
    run_cycles(32, 16'h4321, 4'b1011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
